match_decode_rebuild: RTL

//  Decompression-side counterpart of the compressor's matching-length stage.

---
 rtl/match_decode_rebuild.sv | 93 +++++++++
 1 files changed

// File: rtl/match_decode_rebuild.sv
// Rebuilds original words from decoded match tuples using a move-to-front
// dictionary that mirrors the compressor's, with a 1-cycle registered output.
module match_decode_rebuild #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 16,
    localparam int NB    = WIDTH / 8,
    localparam int LW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_match_s,
    input  logic [NB-1:0]    i_type_matched,
    input  logic [LW-1:0]    i_location,
    input  logic [WIDTH-1:0] i_literal,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_word,
    output logic [LW:0]      o_dict_count,
    output logic             o_err
);

    localparam logic [1:0]  MS_PARTIAL = 2'b01;
    localparam logic [1:0]  MS_FULL    = 2'b10;
    localparam logic [1:0]  MS_RSVD    = 2'b11;
    localparam logic [LW:0] COUNT_FULL = (LW + 1)'(DEPTH);

    logic [WIDTH-1:0] dict [DEPTH];
    logic [LW:0]      dict_count;
    logic             accept;
    logic             is_match;
    logic             loc_oob;
    logic             err_now;
    logic [WIDTH-1:0] entry;
    logic [WIDTH-1:0] rebuilt;

    assign o_ready      = ~o_valid | i_ready;
    assign accept       = i_valid & o_ready;
    assign o_dict_count = dict_count;
    assign entry        = dict[i_location];
    assign is_match     = (i_match_s == MS_PARTIAL) || (i_match_s == MS_FULL);
    assign loc_oob      = {1'b0, i_location} >= dict_count;

    // Reserved code, a full match that still carries literals, and a match
    // beyond the populated region are all flagged but decoded anyway.
    assign err_now = (i_match_s == MS_RSVD)
                   || ((i_match_s == MS_FULL) && (i_type_matched != '0))
                   || (is_match && loc_oob);

    // NOTE: default assignment first, so every path drives rebuilt and no latch is inferred.
    always_comb begin
        rebuilt = i_literal;
        if (is_match) begin
            for (int k = 0; k < NB; k++) begin
                if (!i_type_matched[k]) rebuilt[8*k +: 8] = entry[8*k +: 8];
            end
        end
    end

    // NOTE: the dictionary is reset explicitly because an out-of-range match
    // reads stored entries, so their post-reset contents are visible.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) dict[i] <= '0;
            dict_count <= '0;
        end else if (accept) begin
            // NOTE: non-blocking updates let every entry shift from the pre-edge array.
            dict[0] <= rebuilt;
            for (int i = 1; i < DEPTH; i++) begin
                if (!is_match || (LW'(i) <= i_location)) dict[i] <= dict[i-1];
            end
            if (!is_match && (dict_count != COUNT_FULL)) dict_count <= dict_count + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_word  <= '0;
            o_err   <= 1'b0;
        end else begin
            if (accept) begin
                o_valid <= 1'b1;
                o_word  <= rebuilt;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
            if (accept && err_now) o_err <= 1'b1;
        end
    end

endmodule
